// File: rtl/gth_qpll0_reset_ctrl.sv
// QPLL0 reset/lock sequencer for the GTHE4 common block: reset pulse, lock wait with timeout/retry,
// stability qualification and automatic relock. Define QPLL_RELOCK_CNT_EN to build the relock counter.
module gth_qpll0_reset_ctrl #(
  parameter int RST_PULSE_CYC    = 64,
  parameter int LOCK_TIMEOUT_CYC = 262144,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 3,
  parameter int RETRY_W          = 2
) (
  input  logic               init_clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               qpll0lock_in,
  output logic               qpll0reset_out,
  output logic               qpll_ready,
  output logic               qpll_fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_o,
  output logic [7:0]         relock_cnt
);

  localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_ASSERT_RST = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_STABLE     = 3'd3,
    ST_DONE       = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [TMR_W-1:0]   r_timer;
  logic               w_timer_clr;
  logic               w_timer_run;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_next;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               r_lock_meta;
  logic               r_lock_s;
  logic               r_reset_out;
  logic               r_ready;
  logic               r_fail;

  // qpll0lock_in is asynchronous to init_clk; only r_lock_s is used below
  always_ff @(posedge init_clk) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= qpll0lock_in;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_retry_inc = r_retry + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    case (r_state)
      ST_RESET:      w_state_next = ST_ASSERT_RST;
      ST_ASSERT_RST: if (r_timer == TMR_W'(RST_PULSE_CYC - 1)) w_state_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_next = ST_STABLE;
        end else if (r_timer == TMR_W'(LOCK_TIMEOUT_CYC - 1)) begin
          w_retry_next = w_retry_inc;
          w_state_next = (w_retry_inc == RETRY_W'(MAX_RETRIES)) ? ST_FAIL : ST_ASSERT_RST;
        end
      end
      ST_STABLE: begin
        if (!r_lock_s) begin
          w_state_next = ST_WAIT_LOCK;
        end else if (r_timer == TMR_W'(LOCK_STABLE_CYC - 1)) begin
          w_state_next = ST_DONE;
          w_retry_next = '0;
        end
      end
      ST_DONE:       if (!r_lock_s) w_state_next = ST_ASSERT_RST;
      ST_FAIL:       w_state_next = ST_FAIL;
      default:       w_state_next = ST_RESET;
    endcase
    if (restart) begin
      w_state_next = ST_ASSERT_RST;
      w_retry_next = '0;
    end
  end

  // Timer restarts on every state entry, including a restart that re-enters ASSERT_RST
  assign w_timer_clr = (w_state_next != r_state) || restart;
  assign w_timer_run = (r_state == ST_ASSERT_RST) || (r_state == ST_WAIT_LOCK) ||
                       (r_state == ST_STABLE);

  always_ff @(posedge init_clk) begin
    if (reset) begin
      r_state     <= ST_RESET;
      r_timer     <= '0;
      r_retry     <= '0;
      r_reset_out <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_retry <= w_retry_next;
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (w_timer_run) begin
        r_timer <= r_timer + 1'b1;
      end
      r_reset_out <= (w_state_next == ST_RESET) || (w_state_next == ST_ASSERT_RST) ||
                     (w_state_next == ST_FAIL);
      r_ready     <= (w_state_next == ST_DONE);
      r_fail      <= (w_state_next == ST_FAIL);
    end
  end

`ifdef QPLL_RELOCK_CNT_EN
  logic       w_relock_evt;
  logic [7:0] r_relock_cnt;

  assign w_relock_evt = (r_state == ST_DONE) && !r_lock_s;

  always_ff @(posedge init_clk) begin
    if (reset) begin
      r_relock_cnt <= 8'd0;
    end else if (w_relock_evt && (r_relock_cnt != 8'hFF)) begin
      r_relock_cnt <= r_relock_cnt + 8'd1;
    end
  end

  assign relock_cnt = r_relock_cnt;
`else
  assign relock_cnt = 8'd0;
`endif

  assign qpll0reset_out = r_reset_out;
  assign qpll_ready     = r_ready;
  assign qpll_fail      = r_fail;
  assign retry_cnt      = r_retry;
  assign state_o        = r_state;

endmodule

// File: tb/tb_gth_qpll0_reset_ctrl.sv
// Directed vector bench for gth_qpll0_reset_ctrl: power-up, glitch, timeout, recovery,
// loss of lock, reset/restart priority and relock counter saturation.
module tb_gth_qpll0_reset_ctrl;

  localparam int RST_PULSE_CYC    = 8;
  localparam int LOCK_TIMEOUT_CYC = 100;
  localparam int LOCK_STABLE_CYC  = 16;
  localparam int MAX_RETRIES      = 2;
  localparam int RETRY_W          = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               restart = 1'b0;
  logic               lock = 1'b0;
  logic               qpll0reset_out;
  logic               qpll_ready;
  logic               qpll_fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state_o;
  logic [7:0]         relock_cnt;

  gth_qpll0_reset_ctrl #(
    .RST_PULSE_CYC   (RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
    .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
    .MAX_RETRIES     (MAX_RETRIES),
    .RETRY_W         (RETRY_W)
  ) dut (
    .init_clk      (clk),
    .reset         (reset),
    .restart       (restart),
    .qpll0lock_in  (lock),
    .qpll0reset_out(qpll0reset_out),
    .qpll_ready    (qpll_ready),
    .qpll_fail     (qpll_fail),
    .retry_cnt     (retry_cnt),
    .state_o       (state_o),
    .relock_cnt    (relock_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rstrt;
    logic       lk;
    int         n;
    logic [2:0] st;
    logic       rout;
    logic       rdy;
    logic       fl;
    logic [1:0] rty;
    logic [7:0] rlk;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst, input logic rstrt, input logic lk, input int n,
                     input logic [2:0] st, input logic rout, input logic rdy, input logic fl,
                     input logic [1:0] rty, input logic [7:0] rlk);
    vec_t v;
    v.rst = rst; v.rstrt = rstrt; v.lk = lk; v.n = n;
    v.st = st; v.rout = rout; v.rdy = rdy; v.fl = fl; v.rty = rty; v.rlk = rlk;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] exp_rlk(input logic [7:0] v);
`ifdef QPLL_RELOCK_CNT_EN
    return v;
`else
    return (v == 8'd0) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;

    //   rst rstrt lk  n    st  rout rdy fl rty rlk
    add(1, 0, 0,   5,   0,  1, 0, 0, 0, 0);  // 0  held in reset
    add(0, 0, 0,   1,   1,  1, 0, 0, 0, 0);  // 1  leave RESET
    add(0, 0, 0,   7,   1,  1, 0, 0, 0, 0);  // 2  pulse still high
    add(0, 0, 0,   1,   2,  1'b0, 0, 0, 0, 0);  // 3  8-cycle pulse done
    add(0, 0, 0,  11,   2,  0, 0, 0, 0, 0);  // 4  lock rises 20 cycles after release
    add(0, 0, 1,  18,   3,  0, 0, 0, 0, 0);  // 5  one cycle short of ready
    add(0, 0, 1,   1,   4,  0, 1, 0, 0, 0);  // 6  ready = lock edge + 19
    add(0, 0, 0,   2,   4,  0, 1, 0, 0, 0);  // 7  lock loss not yet seen
    add(0, 0, 0,   1,   1,  1, 0, 0, 0, 1);  // 8  ready drops 3 cycles after fall
    add(0, 0, 0,   7,   1,  1, 0, 0, 0, 1);  // 9
    add(0, 0, 0,   1,   2,  0, 0, 0, 0, 1);  // 10 new 8-cycle pulse done
    add(0, 0, 1,  10,   3,  0, 0, 0, 0, 1);  // 11 glitch: lock high 10
    add(0, 0, 0,   1,   3,  0, 0, 0, 0, 1);  // 12 low 1
    add(0, 0, 1,   2,   2,  0, 0, 0, 0, 1);  // 13 glitch seen, back to WAIT_LOCK
    add(0, 0, 1,  16,   3,  0, 0, 0, 0, 1);  // 14
    add(0, 0, 1,   1,   4,  0, 1, 0, 0, 1);  // 15 ready after 16 clean cycles
    add(0, 0, 0,   3,   1,  1, 0, 0, 0, 2);  // 16 second relock event
    add(0, 0, 0,   8,   2,  0, 0, 0, 0, 2);  // 17
    add(0, 0, 0,  99,   2,  0, 0, 0, 0, 2);  // 18 last waiting cycle
    add(0, 0, 0,   1,   1,  1, 0, 0, 1, 2);  // 19 first timeout
    add(0, 0, 0,   8,   2,  0, 0, 0, 1, 2);  // 20
    add(0, 0, 0,  99,   2,  0, 0, 0, 1, 2);  // 21
    add(0, 0, 0,   1,   5,  1, 0, 1, 2, 2);  // 22 second timeout -> FAIL
    add(0, 0, 0,  20,   5,  1, 0, 1, 2, 2);  // 23 FAIL is sticky
    add(0, 1, 1,   1,   1,  1, 0, 0, 0, 2);  // 24 restart clears fail and retries
    add(0, 0, 1,   7,   1,  1, 0, 0, 0, 2);  // 25
    add(0, 0, 1,   1,   2,  0, 0, 0, 0, 2);  // 26
    add(0, 0, 1,   1,   3,  0, 0, 0, 0, 2);  // 27
    add(0, 0, 1,  15,   3,  0, 0, 0, 0, 2);  // 28
    add(0, 0, 1,   1,   4,  0, 1, 0, 0, 2);  // 29 recovered
    add(0, 1, 0,   1,   1,  1, 0, 0, 0, 2);  // 30 restart in DONE, not a relock
    add(0, 0, 0,   3,   1,  1, 0, 0, 0, 2);  // 31
    add(0, 0, 0,   5,   2,  0, 0, 0, 0, 2);  // 32
    add(0, 0, 0,  10,   2,  0, 0, 0, 0, 2);  // 33 mid-WAIT_LOCK
    add(1, 1, 0,   1,   0,  1, 0, 0, 0, 0);  // 34 reset beats restart
    add(1, 0, 0,   2,   0,  1, 0, 0, 0, 0);  // 35
    add(0, 0, 0,   1,   1,  1, 0, 0, 0, 0);  // 36
    add(0, 0, 0,   8,   2,  0, 0, 0, 0, 0);  // 37
    add(0, 0, 0, 100,   1,  1, 0, 0, 1, 0);  // 38 one failed attempt
    add(0, 0, 1,   8,   2,  0, 0, 0, 1, 0);  // 39
    add(0, 0, 1,   1,   3,  0, 0, 0, 1, 0);  // 40
    add(0, 0, 1,  16,   4,  0, 1, 0, 0, 0);  // 41 DONE entry clears retry_cnt

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      restart = vecs[i].rstrt;
      lock    = vecs[i].lk;
      step(vecs[i].n);
      $display("vec %0d: state=%0d rst_out=%0b ready=%0b fail=%0b retry=%0d relock=%0d",
               i, state_o, qpll0reset_out, qpll_ready, qpll_fail, retry_cnt, relock_cnt);
      check($sformatf("vec%0d state", i), int'(state_o), int'(vecs[i].st));
      check($sformatf("vec%0d qpll0reset_out", i), int'(qpll0reset_out), int'(vecs[i].rout));
      check($sformatf("vec%0d qpll_ready", i), int'(qpll_ready), int'(vecs[i].rdy));
      check($sformatf("vec%0d qpll_fail", i), int'(qpll_fail), int'(vecs[i].fl));
      check($sformatf("vec%0d retry_cnt", i), int'(retry_cnt), int'(vecs[i].rty));
      check($sformatf("vec%0d relock_cnt", i), int'(relock_cnt), int'(exp_rlk(vecs[i].rlk)));
    end
    restart = 1'b0;
    reset   = 1'b0;

    // 300 one-cycle lock dropouts from DONE; the counter must stick at 255
    for (int k = 0; k < 300; k++) begin
      lock = 1'b0;
      step(1);
      lock = 1'b1;
      waited = 0;
      while (qpll_ready && waited < 10) begin
        step(1);
        waited++;
      end
      check($sformatf("relock%0d ready_drop", k), int'(qpll_ready), 0);
      waited = 0;
      while (!qpll_ready && waited < 100) begin
        step(1);
        waited++;
      end
      check($sformatf("relock%0d ready_back", k), int'(qpll_ready), 1);
      if (k == 9) check("relock_cnt after 10", int'(relock_cnt), int'(exp_rlk(8'd10)));
    end
    $display("relock sweep: relock_cnt=%0d retry=%0d", relock_cnt, retry_cnt);
    check("relock_cnt saturated", int'(relock_cnt), int'(exp_rlk(8'd255)));
    check("retry_cnt after relocks", int'(retry_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
